// File: rtl/audio_codec_pkg.sv
// Shared constants, framer state encoding and LRCK-to-state helper for the codec-side audio target.
package audio_codec_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;

    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } framer_e;

    // Channel state entered after an LRCK edge, given the new LRCK level.
    function automatic framer_e lrck_state(input logic lrck);
        framer_e s;
        s = HUNT;
        if (lrck == CH_LEFT)  s = LEFT;
        if (lrck == CH_RIGHT) s = RIGHT;
        return s;
    endfunction

endpackage

// File: rtl/audio_codec_edge_sync.sv
// Oversampling synchronizer for one codec pin: SYNC_STAGES flops plus a history flop
// for edge detection. The edge pulses are combinational from flops (_c).
module audio_codec_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/audio_codec_target.sv
// Codec-side audio target: deserializes DACDAT into left/right pairs and serializes
// ADC pairs onto ADCDAT, left-justified MSB-first, all in the local clk domain.
module audio_codec_target
    import audio_codec_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                AUD_BCLK,
    input  logic                AUD_DACLRCK,
    input  logic                AUD_ADCLRCK,
    input  logic                AUD_DACDAT,
    output logic                AUD_ADCDAT,
    output logic [SAMPLE_W-1:0] dac_left,
    output logic [SAMPLE_W-1:0] dac_right,
    output logic                dac_valid,
    output logic                dac_frame_err,
    input  logic [SAMPLE_W-1:0] adc_left,
    input  logic [SAMPLE_W-1:0] adc_right,
    output logic                adc_load
);

    localparam int unsigned     CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SAMPLE_W);

    logic bclk_rise, bclk_fall, dlr_rise, dlr_fall, alr_rise, alr_fall, dat_sync;
    logic unused_bclk_lvl, unused_dlr_lvl, unused_alr_lvl, unused_dat_rise, unused_dat_fall;

    audio_codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .reset(reset), .pin_i(AUD_BCLK),
        .sync_o(unused_bclk_lvl), .rise_c(bclk_rise), .fall_c(bclk_fall)
    );
    audio_codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_daclrck (
        .clk(clk), .reset(reset), .pin_i(AUD_DACLRCK),
        .sync_o(unused_dlr_lvl), .rise_c(dlr_rise), .fall_c(dlr_fall)
    );
    audio_codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adclrck (
        .clk(clk), .reset(reset), .pin_i(AUD_ADCLRCK),
        .sync_o(unused_alr_lvl), .rise_c(alr_rise), .fall_c(alr_fall)
    );
    // Same depth as BCLK so the sampled data bit lines up with the detected rising edge.
    audio_codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dacdat (
        .clk(clk), .reset(reset), .pin_i(AUD_DACDAT),
        .sync_o(dat_sync), .rise_c(unused_dat_rise), .fall_c(unused_dat_fall)
    );

    framer_e               dac_state_q, dac_state_d;
    logic [SAMPLE_W-1:0]   dac_sr_q, dac_sr_d;
    logic [SAMPLE_W-1:0]   dac_hold_q, dac_hold_d;
    logic [SAMPLE_W-1:0]   dac_left_q, dac_left_d;
    logic [SAMPLE_W-1:0]   dac_right_q, dac_right_d;
    logic [CNT_W-1:0]      dac_cnt_q, dac_cnt_d;
    logic                  dac_lok_q, dac_lok_d;
    logic                  dac_valid_q, dac_valid_d;
    logic                  dac_err_q, dac_err_d;

    // DAC framer: LRCK edge clears the word first, so a coincident BCLK rise becomes bit 0.
    always_comb begin
        dac_state_d = dac_state_q;
        dac_sr_d    = dac_sr_q;
        dac_hold_d  = dac_hold_q;
        dac_left_d  = dac_left_q;
        dac_right_d = dac_right_q;
        dac_cnt_d   = dac_cnt_q;
        dac_lok_d   = dac_lok_q;
        dac_valid_d = 1'b0;
        dac_err_d   = 1'b0;
        if ((dlr_rise || dlr_fall) && (dac_state_q != HUNT || dlr_rise)) begin
            if (dac_state_q != HUNT && dac_cnt_q != '0 && dac_cnt_q < FULL) begin
                dac_err_d = 1'b1;
            end
            dac_state_d = lrck_state(dlr_rise);
            dac_sr_d    = '0;
            dac_cnt_d   = '0;
            if (dlr_rise) dac_lok_d = 1'b0;
        end
        if (bclk_rise && dac_state_d != HUNT && dac_cnt_d < FULL) begin
            dac_sr_d  = {dac_sr_d[SAMPLE_W-2:0], dat_sync};
            dac_cnt_d = dac_cnt_d + CNT_W'(1);
            if (dac_cnt_d == FULL) begin
                if (dac_state_d == LEFT) begin
                    dac_hold_d = dac_sr_d;
                    dac_lok_d  = 1'b1;
                end else if (dac_lok_d) begin
                    dac_left_d  = dac_hold_q;
                    dac_right_d = dac_sr_d;
                    dac_valid_d = 1'b1;
                    dac_lok_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_state_q <= HUNT;
            dac_sr_q    <= '0;
            dac_hold_q  <= '0;
            dac_left_q  <= '0;
            dac_right_q <= '0;
            dac_cnt_q   <= '0;
            dac_lok_q   <= 1'b0;
            dac_valid_q <= 1'b0;
            dac_err_q   <= 1'b0;
        end else begin
            dac_state_q <= dac_state_d;
            dac_sr_q    <= dac_sr_d;
            dac_hold_q  <= dac_hold_d;
            dac_left_q  <= dac_left_d;
            dac_right_q <= dac_right_d;
            dac_cnt_q   <= dac_cnt_d;
            dac_lok_q   <= dac_lok_d;
            dac_valid_q <= dac_valid_d;
            dac_err_q   <= dac_err_d;
        end
    end

    framer_e             adc_state_q, adc_state_d;
    logic [SAMPLE_W-1:0] adc_sr_q, adc_sr_d;
    logic [SAMPLE_W-1:0] adc_tmp_q, adc_tmp_d;
    logic                adc_load_q, adc_load_d;

    // ADC framer: an LRCK load takes priority over a coincident BCLK-falling shift.
    always_comb begin
        adc_state_d = adc_state_q;
        adc_sr_d    = adc_sr_q;
        adc_tmp_d   = adc_tmp_q;
        adc_load_d  = 1'b0;
        if (alr_rise) begin
            adc_state_d = lrck_state(CH_LEFT);
            adc_tmp_d   = adc_right;
            adc_sr_d    = adc_left;
            adc_load_d  = 1'b1;
        end else if (alr_fall && adc_state_q != HUNT) begin
            adc_state_d = lrck_state(CH_RIGHT);
            adc_sr_d    = adc_tmp_q;
        end else if (bclk_fall) begin
            adc_sr_d = {adc_sr_q[SAMPLE_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_state_q <= HUNT;
            adc_sr_q    <= '0;
            adc_tmp_q   <= '0;
            adc_load_q  <= 1'b0;
        end else begin
            adc_state_q <= adc_state_d;
            adc_sr_q    <= adc_sr_d;
            adc_tmp_q   <= adc_tmp_d;
            adc_load_q  <= adc_load_d;
        end
    end

    assign AUD_ADCDAT    = adc_sr_q[SAMPLE_W-1];
    assign dac_left      = dac_left_q;
    assign dac_right     = dac_right_q;
    assign dac_valid     = dac_valid_q;
    assign dac_frame_err = dac_err_q;
    assign adc_load      = adc_load_q;

endmodule

// File: tb/tb_audio_codec_target.sv
// Bench for audio_codec_target: a master BFM drives BCLK/LRCKs/DACDAT and reads ADCDAT,
// with frame-level expectations for playback pairs, frame errors and capture words.
module tb_audio_codec_target;

    localparam int unsigned W    = 16;
    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         AUD_BCLK, AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT, AUD_ADCDAT;
    logic [W-1:0] dac_left, dac_right, adc_left, adc_right;
    logic         dac_valid, dac_frame_err, adc_load;

    always #5 clk = ~clk;

    audio_codec_target #(.SAMPLE_W(W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset),
        .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_ADCLRCK(AUD_ADCLRCK),
        .AUD_DACDAT(AUD_DACDAT), .AUD_ADCDAT(AUD_ADCDAT),
        .dac_left(dac_left), .dac_right(dac_right),
        .dac_valid(dac_valid), .dac_frame_err(dac_frame_err),
        .adc_left(adc_left), .adc_right(adc_right), .adc_load(adc_load)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0]  dac_exp_q[$];
    logic [31:0]  adc_exp_q[$];
    logic [31:0]  pair;
    int           exp_err = 0, obs_err = 0, adc_rises = 0, obs_loads = 0, adc_idx = 0;
    logic         prev_adc_lr = 1'b0;
    logic         adc_armed = 1'b0;
    logic         adc_rand = 1'b0;
    logic         skew = 1'b0;
    logic [W-1:0] cur_l = '0, cur_r = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Playback monitor: each dac_valid must match the oldest expected complete pair.
    always @(negedge clk) begin
        if (dac_valid) begin
            check_eq("dac_valid_q", dac_exp_q.size(), 1);
            if (dac_exp_q.size() != 0) begin
                pair = dac_exp_q.pop_front();
                check_eq("dac_left", dac_left, pair[31:16]);
                check_eq("dac_right", dac_right, pair[15:0]);
            end
        end
        if (dac_frame_err) obs_err++;
    end

    // One BCLK period: change pins at the falling edge, read ADCDAT just before rising.
    task automatic bclk_cycle(input logic dlr, input logic dbit, input logic alr);
        logic         rise_a;
        logic [W-1:0] w;
        logic         expb;
        rise_a = alr && !prev_adc_lr;
        if (alr != prev_adc_lr) adc_idx = 0;
        prev_adc_lr = alr;
        if (rise_a) adc_rises++;
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = dlr;
        AUD_ADCLRCK = alr;
        AUD_DACDAT  = dbit;
        for (int j = 1; j <= int'(2 * HALF); j++) begin
            @(negedge clk);
            check_eq("adc_load", adc_load, rise_a && (j == int'(SYNC + 1)));
            if (adc_load) begin
                obs_loads++;
                adc_exp_q.push_back({adc_left, adc_right});
                if (adc_rand) begin
                    adc_left  = 16'($urandom);
                    adc_right = 16'($urandom);
                end
            end
            if (j == int'(HALF)) begin
                if (rise_a) begin
                    check_eq("adc_load_q", adc_exp_q.size() != 0, 1);
                    if (adc_exp_q.size() != 0) begin
                        {cur_l, cur_r} = adc_exp_q.pop_front();
                        adc_armed = 1'b1;
                    end
                end
                w    = alr ? cur_l : cur_r;
                expb = 1'b0;
                if (adc_armed && adc_idx < int'(W)) expb = w[W-1-adc_idx];
                check_eq("adcdat", AUD_ADCDAT, expb);
                adc_idx++;
                AUD_BCLK = 1'b1;
            end
        end
    endtask

    task automatic dac_bit(input logic [W-1:0] wd, input int i, output logic b);
        b = 1'b1;
        if (i < int'(W)) b = wd[W-1-i];
    endtask

    // One LRCK frame with nl left and nr right BCLKs; bits past W are sent as 1.
    task automatic send_frame(input int nl, input int nr, input logic [W-1:0] wl, input logic [W-1:0] wr);
        logic b;
        if (nl >= int'(W) && nr >= int'(W)) dac_exp_q.push_back({wl, wr});
        if (nl > 0 && nl < int'(W)) exp_err++;
        if (nr > 0 && nr < int'(W)) exp_err++;
        for (int i = 0; i < nl; i++) begin
            dac_bit(wl, i, b);
            bclk_cycle(1'b1, b, ~skew);
        end
        for (int i = 0; i < nr; i++) begin
            dac_bit(wr, i, b);
            bclk_cycle(1'b0, b, skew);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_adcdat"}, AUD_ADCDAT, 0);
        check_eq({tag, "_dac_left"}, dac_left, 0);
        check_eq({tag, "_dac_right"}, dac_right, 0);
        check_eq({tag, "_dac_valid"}, dac_valid, 0);
        check_eq({tag, "_frame_err"}, dac_frame_err, 0);
        check_eq({tag, "_adc_load"}, adc_load, 0);
    endtask

    initial begin
        logic b;
        reset       = 1'b1;
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = 1'b0;
        AUD_ADCLRCK = 1'b0;
        AUD_DACDAT  = 1'b0;
        adc_left    = 16'h8001;
        adc_right   = 16'h7FFE;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int f = 0; f < 4; f++) send_frame(W, W, 16'hA5C3, 16'h1234);
        for (int f = 0; f < 3; f++) send_frame(20, 20, 16'hA5C3, 16'h1234);
        send_frame(10, W, 16'hDEAD, 16'hBEEF);
        for (int f = 0; f < 2; f++) send_frame(W, W, 16'hA5C3, 16'h1234);

        adc_rand  = 1'b1;
        adc_left  = 16'($urandom);
        adc_right = 16'($urandom);
        for (int f = 0; f < 4; f++) send_frame(W, W, 16'($urandom), 16'($urandom));
        adc_rand  = 1'b0;
        adc_left  = 16'h8001;
        adc_right = 16'h7FFE;
        send_frame(W, W, 16'hA5C3, 16'h1234);

        // Async reset in the middle of the right word.
        for (int i = 0; i < int'(W); i++) begin
            dac_bit(16'h5A5A, i, b);
            bclk_cycle(1'b1, b, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            dac_bit(16'h3C3C, i, b);
            bclk_cycle(1'b0, b, 1'b0);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dac_exp_q.delete();
        adc_exp_q.delete();
        adc_armed = 1'b0;
        for (int i = 8; i < int'(W); i++) begin
            dac_bit(16'h3C3C, i, b);
            bclk_cycle(1'b0, b, 1'b0);
        end
        check_eq("post_rst_left", dac_left, 0);
        for (int f = 0; f < 2; f++) send_frame(W, W, 16'hA5C3, 16'h1234);

        skew      = 1'b1;
        adc_left  = 16'hFFFF;
        adc_right = 16'h0000;
        for (int f = 0; f < 4; f++) send_frame(W, W, 16'hA5C3, 16'h1234);

        repeat (20) @(negedge clk);
        check_eq("frame_err_cnt", obs_err, exp_err);
        check_eq("dac_pairs_pending", dac_exp_q.size(), 0);
        check_eq("adc_load_cnt", obs_loads, adc_rises);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
